// File: rtl/note_pkg.sv
// Shared definitions for the note recorder and the playback block: entry packing
// convention (freq1 in the most-significant field) and the recorder state enum.
package note_pkg;

  localparam int FREQ_W  = 12;
  localparam int ENTRY_W = 4 * FREQ_W;

  typedef logic [ENTRY_W-1:0] entry_t;

  typedef enum logic [1:0] {
    REC_IDLE = 2'd0,
    REC_RUN  = 2'd1,
    REC_DONE = 2'd2
  } rec_state_e;

  function automatic entry_t pack_entry(input logic [FREQ_W-1:0] f1,
                                        input logic [FREQ_W-1:0] f2,
                                        input logic [FREQ_W-1:0] f3,
                                        input logic [FREQ_W-1:0] f4);
    return {f1, f2, f3, f4};
  endfunction

  // voice 0 is freq1 (MS field), voice 3 is freq4 (LS field)
  function automatic logic [FREQ_W-1:0] unpack_voice(input entry_t e, input logic [1:0] voice);
    logic [FREQ_W-1:0] v;
    case (voice)
      2'd0:    v = e[4*FREQ_W-1:3*FREQ_W];
      2'd1:    v = e[3*FREQ_W-1:2*FREQ_W];
      2'd2:    v = e[2*FREQ_W-1:FREQ_W];
      default: v = e[FREQ_W-1:0];
    endcase
    return v;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter: tick is high while the count is zero; when enabled at
// zero it reloads instead of wrapping. Shared by recording and playback timing.
module step_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign tick = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = tick ? load_val : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/note_recorder.sv
// Records four live voice frequencies into note memory once every STEP_CYCLES.
// Build option NOTE_RECORDER_LOOP_EN: circular take that wraps until stop.
module note_recorder #(
  parameter int FREQ_W      = note_pkg::FREQ_W,
  parameter int ADDR_W      = 8,
  parameter int STEP_CYCLES = 50
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic [FREQ_W-1:0]       freq1,
  input  logic [FREQ_W-1:0]       freq2,
  input  logic [FREQ_W-1:0]       freq3,
  input  logic [FREQ_W-1:0]       freq4,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [4*FREQ_W-1:0]     wr_data,
  output logic                    recording,
  output logic                    full,
  output logic [ADDR_W:0]         count,
  output note_pkg::rec_state_e    state_dbg
);

  import note_pkg::*;

  localparam int                TMR_W     = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TMR_W-1:0]  RELOAD    = TMR_W'(STEP_CYCLES - 1);
  localparam logic [ADDR_W:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  rec_state_e              state_d, state_q;
  logic                    wr_en_d, wr_en_q;
  logic [ADDR_W-1:0]       wr_addr_d, wr_addr_q;
  logic [4*FREQ_W-1:0]     wr_data_d, wr_data_q;
  logic                    full_d, full_q;
  logic [ADDR_W:0]         count_d, count_q;
  logic                    tmr_load, tmr_en, tmr_tick;
  logic [4*FREQ_W-1:0]     entry_in;
  logic [ADDR_W-1:0]       wr_addr_inc;

  assign entry_in    = {freq1, freq2, freq3, freq4};
  assign wr_addr_inc = wr_addr_q + 1'b1;

  step_timer #(
    .CNT_W    (TMR_W)
  ) u_step_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (RELOAD),
    .tick     (tmr_tick)
  );

  // Write port: wr_en is a one-cycle strobe with no back-pressure; wr_addr and
  // wr_data are valid while it is high and hold their last value between writes.
  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    full_d    = full_q;
    count_d   = count_q;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      REC_IDLE, REC_DONE: begin
        if (start && !stop) begin
          state_d   = REC_RUN;
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = entry_in;
          full_d    = 1'b0;
          count_d   = {{ADDR_W{1'b0}}, 1'b1};
          tmr_load  = 1'b1;
        end
      end
      REC_RUN: begin
        tmr_en = 1'b1;
        if (stop) begin
          state_d = REC_IDLE;
`ifndef NOTE_RECORDER_LOOP_EN
        end else if (full_q) begin
          // the final entry went out on the previous edge
          state_d = REC_DONE;
`endif
        end else if (tmr_tick) begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_inc;
          wr_data_d = entry_in;
          if (count_q != DEPTH) begin
            count_d = count_q + 1'b1;
          end
`ifdef NOTE_RECORDER_LOOP_EN
          if (wr_addr_q == LAST_ADDR) begin
            full_d = 1'b1;
          end
`else
          if (wr_addr_inc == LAST_ADDR) begin
            full_d = 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = REC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= REC_IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      full_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      full_q    <= full_d;
      count_q   <= count_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign full      = full_q;
  assign count     = count_q;
  assign recording = (state_q == REC_RUN);
  assign state_dbg = state_q;

endmodule
